// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM encodings, frame constants and baud divider rounding.
// Kept separate so a future receiver can reuse the same constants.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Clock cycles per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the transmitter: register-array storage, head word always visible,
// level counter separates full from empty because the pointers wrap modulo DEPTH.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [$clog2(DEPTH):0]   o_level_nx
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // A push while full is dropped even when a pop happens on the same edge.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_comb begin
        o_level_nx = r_level;
        case ({w_push, w_pop})
            2'b10:   o_level_nx = r_level + LW'(1);
            2'b01:   o_level_nx = r_level - LW'(1);
            default: o_level_nx = r_level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_level <= o_level_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised LSB-first at a fixed baud rate.
// The tx flop follows the state of the previous cycle, so a frame starts two edges after a push.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int IW  = $clog2(UART_DATA_BITS);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);
    localparam logic [IW-1:0] LAST_BIT   = IW'(UART_DATA_BITS - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx: clock/baud ratio must give at least 2 cycles per bit");
        end
    endgenerate

    uart_state_t     r_state;
    uart_state_t     w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nx;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nx;
    logic            r_tx;
    logic            r_busy;
    logic            w_pop;
    logic            w_push;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_head;
    logic [LW-1:0]   w_level;
    logic [LW-1:0]   w_level_nx;

    assign w_push = wr_valid && !w_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_data     (wr_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level),
        .o_level_nx (w_level_nx)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        case (r_state)
            UART_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_idx_nx   = '0;
                    w_cnt_nx   = CNT_RELOAD;
                    w_state_nx = UART_START;
                end
            end
            UART_START: begin
                if (r_cnt == '0) begin
                    w_cnt_nx   = CNT_RELOAD;
                    w_state_nx = UART_DATA;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            UART_DATA: begin
                if (r_cnt == '0) begin
                    w_cnt_nx   = CNT_RELOAD;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_idx == LAST_BIT) begin
                        w_state_nx = UART_STOP;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            UART_STOP: begin
                if (r_cnt == '0) begin
                    // Chain straight into the next start bit so queued frames are contiguous.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_head;
                        w_idx_nx   = '0;
                        w_cnt_nx   = CNT_RELOAD;
                        w_state_nx = UART_START;
                    end else begin
                        w_state_nx = UART_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            case (r_state)
                UART_START: r_tx <= 1'b0;
                UART_DATA:  r_tx <= r_shift[0];
                default:    r_tx <= 1'b1;
            endcase
            r_busy <= (w_state_nx != UART_IDLE) || (w_level_nx != '0);
        end
    end

    assign wr_ready   = !w_full;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_level = w_level;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at DIV=10: per-cycle frame tables, a line decoder feeding a byte
// scoreboard, and directed sequences for queueing, full-FIFO, reset-abort and push/pop overlap.
module tb_uart_tx;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int BAUD        = 100;
    localparam int FIFO_DEPTH  = 4;
    localparam int LW          = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          tx;
    logic          busy;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            step(1);
            n++;
        end
        chk("wait_idle_in_budget", (n < 2000), 1);
        step(10);
    endtask

    // Line decoder: samples mid-bit on the falling clock edge and checks against the scoreboard.
    int         m_cnt = 0;
    logic       m_act = 1'b0;
    logic [7:0] m_byte = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (tx === 1'b0) begin
                m_act = 1'b1;
                m_cnt = 1;
            end
        end else begin
            if (m_cnt == 5) begin
                chk("mon_start_bit", tx, 0);
            end else if (m_cnt >= 15 && m_cnt <= 85 && (m_cnt % 10) == 5) begin
                m_byte[(m_cnt - 15) / 10] = tx;
            end else if (m_cnt == 95) begin
                chk("mon_stop_bit", tx, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_byte: got %0h expected none at t=%0t", m_byte, $time);
                end else begin
                    chk("mon_byte", m_byte, exp_q.pop_front());
                end
                m_act = 1'b0;
            end
            m_cnt++;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[3];

    // Push one byte from idle and check every cycle of its frame; frame[k] is the line level of bit k.
    task automatic check_frame(input logic [7:0] d, input logic [9:0] frame);
        wr_data  = d;
        wr_valid = 1'b1;
        exp_q.push_back(d);
        step(1);
        wr_valid = 1'b0;
        chk("push_level", fifo_level, 1);
        chk("push_busy", busy, 1);
        chk("push_tx_idle", tx, 1);
        chk("push_ready", wr_ready, 1);
        step(1);
        chk("pop_tx_still_idle", tx, 1);
        chk("pop_level", fifo_level, 0);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 10; c++) begin
                step(1);
                chk($sformatf("frame_%02h_bit%0d", d, k), tx, frame[k]);
                if (c == 9) chk($sformatf("frame_%02h_busy%0d", d, k), busy, (k == 9) ? 0 : 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'hFE, frame: 10'b1111111100};
        vecs[2] = '{data: 8'h3C, frame: 10'b1001111000};

        // Reset state, applied asynchronously before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", wr_ready, 1);
        chk("rst_level", fifo_level, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step(1);

        // Single frames, cycle-exact.
        for (int i = 0; i < 3; i++) begin
            check_frame(vecs[i].data, vecs[i].frame);
            wait_idle();
        end

        // Three consecutive pushes: contiguous frames, level peaks at 2.
        wr_valid = 1'b1;
        wr_data = 8'h00; exp_q.push_back(8'h00); step(1);
        wr_data = 8'hFF; exp_q.push_back(8'hFF); step(1);
        wr_data = 8'h55; exp_q.push_back(8'h55); step(1);
        wr_valid = 1'b0;
        chk("t3_level_peak", fifo_level, 2);
        chk("t3_f0_start", tx, 0);
        step(99);
        chk("t3_f0_stop", tx, 1);
        chk("t3_level_after_pop1", fifo_level, 1);
        step(1);
        chk("t3_f1_start_no_gap", tx, 0);
        step(99);
        chk("t3_f1_stop", tx, 1);
        chk("t3_level_after_pop2", fifo_level, 0);
        step(1);
        chk("t3_f2_start_no_gap", tx, 0);
        step(98);
        chk("t3_busy_last_cycle", busy, 1);
        step(1);
        chk("t3_busy_fall", busy, 0);
        wait_idle();

        // Six bytes with wr_valid held: fifth fills the FIFO, sixth waits for the first STOP pop.
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'h10 + 8'(i);
            exp_q.push_back(wr_data);
            step(1);
        end
        chk("t4_full_ready", wr_ready, 0);
        chk("t4_full_level", fifo_level, 4);
        wr_data = 8'h6B;
        exp_q.push_back(8'h6B);
        step(96);
        chk("t4_still_full_ready", wr_ready, 0);
        chk("t4_still_full_level", fifo_level, 4);
        step(1);
        chk("t4_pop_ready", wr_ready, 1);
        chk("t4_drop_level", fifo_level, 3);
        step(1);
        wr_valid = 1'b0;
        chk("t4_accept_level", fifo_level, 4);
        chk("t4_refull_ready", wr_ready, 0);
        wait_idle();

        // Push on the same edge as the STOP-completion pop with three queued.
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'hC0 + 8'(i);
            exp_q.push_back(wr_data);
            step(1);
        end
        wr_valid = 1'b0;
        chk("t6_level3", fifo_level, 3);
        step(97);
        chk("t6_level_before", fifo_level, 3);
        wr_valid = 1'b1;
        wr_data = 8'hC4;
        exp_q.push_back(8'hC4);
        step(1);
        wr_valid = 1'b0;
        chk("t6_level_same_edge", fifo_level, 3);
        chk("t6_ready", wr_ready, 1);
        step(1);
        chk("t6_next_start_no_gap", tx, 0);
        wait_idle();

        // Reset mid-cycle during data bit 3 of 0x3C with two bytes queued.
        wr_valid = 1'b1;
        wr_data = 8'h3C; exp_q.push_back(8'h3C); step(1);
        wr_data = 8'h11; exp_q.push_back(8'h11); step(1);
        wr_data = 8'h22; exp_q.push_back(8'h22); step(1);
        wr_valid = 1'b0;
        chk("t5_level_queued", fifo_level, 2);
        step(43);
        chk("t5_busy_pre", busy, 1);
        chk("t5_tx_bit3", tx, 1);
        #3 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", wr_ready, 1);
        chk("t5_rst_level", fifo_level, 0);
        step(2);
        chk("t5_rst_hold_tx", tx, 1);
        @(negedge clk) rst = 1'b0;
        step(1);
        check_frame(8'h81, 10'b1100000010);
        wait_idle();
        step(20);
        chk("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
